// File: rtl/sda_pkg.sv
// sda_pkg: shared receiver states, default sizing and the one-hot decode used by display logic
package sda_pkg;
  localparam int NBITS_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int OH_MAX = 256;
  typedef enum logic [1:0] {IDLE = 2'd0, BITS = 2'd1, STOP_WAIT = 2'd2} state_e;
  function automatic logic [OH_MAX-1:0] onehot(input logic [7:0] v);
    onehot = '0;
    onehot[v] = 1'b1;
  endfunction
endpackage

// File: rtl/sda_rx_if.sv
// sda_rx_if: two-wire bus inputs and the parallel word outputs of the receiver
interface sda_rx_if import sda_pkg::*; #(parameter int NBITS = NBITS_DEF);
  logic scl;
  logic sda;
  logic [NBITS-1:0] data;
  logic data_valid;
  logic frame_err;
  logic busy;
  logic [2**NBITS-1:0] outhigh;
  modport master(output scl, sda, input data, data_valid, frame_err, busy, outhigh);
  modport slave(input scl, sda, output data, data_valid, frame_err, busy, outhigh);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchroniser plus previous-sample register, idling high like the bus
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic p
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      ff <= '1;
      p <= 1'b1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
      p <= ff[STAGES-1];
    end
  assign s = ff[STAGES-1];
endmodule

// File: rtl/sda_rx.sv
// sda_rx: two-wire frame receiver with start/stop detection, framing checks and one-hot output
module sda_rx import sda_pkg::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic sclk,
  input logic rst,
  sda_rx_if.slave bus
);
  localparam int CW = $clog2(NBITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int OW = 2 ** NBITS;
  logic scl_s, scl_p, sda_s, sda_p, start, stop, rise, done, tmo_hit;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [NBITS-1:0] sr;
  logic [TW-1:0] tmo;
  sync_edge #(.STAGES(SYNC_STAGES)) u_scl (.sclk(sclk), .rst(rst), .d(bus.scl), .s(scl_s), .p(scl_p));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sda (.sclk(sclk), .rst(rst), .d(bus.sda), .s(sda_s), .p(sda_p));
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop = scl_s & scl_p & ~sda_p & sda_s;
  assign rise = scl_s & ~scl_p;
  assign done = stop & (state == STOP_WAIT);
  assign tmo_hit = tmo == TW'(TIMEOUT);
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      tmo <= '0;
      bus.data <= '0;
      bus.outhigh <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
      tmo <= (state == IDLE || scl_s != scl_p) ? '0 : tmo + TW'(!tmo_hit);
      if (start) begin
        // a start inside an open frame is a repeated start: restart capture, flag the lost frame
        state <= BITS;
        cnt <= '0;
        sr <= '0;
        bus.busy <= 1'b1;
        bus.frame_err <= state != IDLE;
      end else if (state != IDLE && (stop || tmo_hit)) begin
        state <= IDLE;
        bus.busy <= 1'b0;
        bus.data_valid <= done;
        bus.frame_err <= !done;
        if (done) begin
          bus.data <= sr;
          bus.outhigh <= OW'(onehot(8'(sr)));
        end
      end else if (rise && state == BITS) begin
        sr <= {sr[NBITS-2:0], sda_s};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(NBITS - 1)) state <= STOP_WAIT;
      end
    end
endmodule

// File: tb/tb_sda_rx.sv
// tb_sda_rx: randomized bus frames checked every cycle against a queue-based behavioural model
module tb_sda_rx;
  localparam int NB = 4;
  localparam int S = 2;
  localparam int TO = 64;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0;
  int cyc = 0, n_dv = 0, n_fe = 0, dv_cyc = 0, stop_cyc = 0;
  logic [1:0] hist[$];
  bit mbits[$];
  bit m_open;
  int idle;
  logic [3:0] e_data;
  logic [15:0] e_oh;
  logic e_dv, e_fe, e_busy;

  sda_rx_if #(.NBITS(NB)) bus ();
  sda_rx #(.NBITS(NB), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (.sclk(sclk), .rst(rst), .bus(bus.slave));

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (S + 1) hist.push_back(2'b11);
    m_open = 0;
    mbits.delete();
    idle = 0;
    e_data = '0;
    e_oh = '0;
    e_dv = 0;
    e_fe = 0;
    e_busy = 0;
  endtask

  // predicts the outputs after the coming sclk edge; hist[0] is the previous synced sample, hist[1] the current
  task automatic model_step();
    logic pc, pd, sc, sd, st, sp, ri;
    bit was_open;
    int v;
    {pc, pd} = hist[0];
    {sc, sd} = hist[1];
    st = sc & pc & pd & !sd;
    sp = sc & pc & !pd & sd;
    ri = sc & !pc;
    was_open = m_open;
    e_dv = 0;
    e_fe = 0;
    if (st) begin
      e_fe = m_open;
      m_open = 1;
      mbits.delete();
    end else if (m_open && sp) begin
      if (mbits.size() == NB) begin
        v = 0;
        foreach (mbits[i]) v = v * 2 + int'(mbits[i]);
        e_data = 4'(v);
        e_oh = 16'd1 << v;
        e_dv = 1;
      end else e_fe = 1;
      m_open = 0;
    end else if (m_open && idle == TO) begin
      e_fe = 1;
      m_open = 0;
    end else if (m_open && ri && mbits.size() < NB) mbits.push_back(sd);
    idle = (!was_open || sc != pc) ? 0 : (idle < TO ? idle + 1 : idle);
    e_busy = m_open;
    void'(hist.pop_front());
    hist.push_back({bus.scl, bus.sda});
  endtask

  initial forever begin
    @(negedge sclk);
    #1;
    if (rst) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge sclk);
    chk("data", 32'(bus.data), rst ? 32'd0 : 32'(e_data));
    chk("outhigh", 32'(bus.outhigh), rst ? 32'd0 : 32'(e_oh));
    chk("data_valid", 32'(bus.data_valid), rst ? 32'd0 : 32'(e_dv));
    chk("frame_err", 32'(bus.frame_err), rst ? 32'd0 : 32'(e_fe));
    chk("busy", 32'(bus.busy), rst ? 32'd0 : 32'(e_busy));
    chk("dv_fe_exclusive", 32'(bus.data_valid & bus.frame_err), 32'd0);
    if (bus.data_valid) begin
      n_dv++;
      dv_cyc = cyc;
    end
    if (bus.frame_err) n_fe++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(posedge sclk);
    #2;
  endtask
  task automatic do_start(input int hi);
    bus.sda = 1'b0;
    wait_n(hi);
  endtask
  task automatic do_bit(input logic b, input int lo1, input int lo2, input int hi);
    bus.scl = 1'b0;
    wait_n(lo1);
    bus.sda = b;
    wait_n(lo2);
    bus.scl = 1'b1;
    wait_n(hi);
  endtask
  task automatic do_stop(input int hi);
    stop_cyc = cyc;
    bus.sda = 1'b1;
    wait_n(hi);
  endtask
  task automatic frame(input logic [3:0] v, input int lo1, input int lo2, input int hi);
    do_start(hi);
    for (int i = NB - 1; i >= 0; i--) do_bit(v[i], lo1, lo2, hi);
    do_bit(1'b0, lo1, lo2, hi);
    do_stop(hi);
  endtask

  initial begin
    int d0, f0, kind, lo1, lo2, hi, n;
    logic [3:0] v;
    bus.scl = 1'b1;
    bus.sda = 1'b1;
    wait_n(4);
    rst = 1'b0;
    wait_n(4);
    chk("reset_data", 32'(bus.data), 32'd0);
    chk("reset_outhigh", 32'(bus.outhigh), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    d0 = n_dv;
    frame(4'b1011, 2, 2, 4);
    wait_n(4);
    chk("f1011_dv_count", 32'(n_dv - d0), 32'd1);
    chk("f1011_latency", 32'(dv_cyc - stop_cyc), 32'(S + 1));
    chk("f1011_data", 32'(bus.data), 32'hB);
    chk("f1011_outhigh", 32'(bus.outhigh), 32'h0800);
    chk("f1011_busy", 32'(bus.busy), 32'd0);
    chk("f1011_model", 32'(e_data), 32'hB);

    d0 = n_dv;
    f0 = n_fe;
    do_start(4);
    do_bit(1'b1, 2, 2, 4);
    do_bit(1'b0, 2, 2, 4);
    do_stop(4);
    wait_n(4);
    chk("short_fe_count", 32'(n_fe - f0), 32'd1);
    chk("short_dv_count", 32'(n_dv - d0), 32'd0);
    chk("short_data_kept", 32'(bus.data), 32'hB);
    chk("short_outhigh_kept", 32'(bus.outhigh), 32'h0800);

    d0 = n_dv;
    frame(4'b0000, 2, 2, 4);
    chk("b2b_data0", 32'(bus.data), 32'h0);
    chk("b2b_outhigh0", 32'(bus.outhigh), 32'h0001);
    frame(4'b1111, 2, 2, 4);
    wait_n(4);
    chk("b2b_dataF", 32'(bus.data), 32'hF);
    chk("b2b_outhighF", 32'(bus.outhigh), 32'h8000);
    chk("b2b_dv_count", 32'(n_dv - d0), 32'd2);

    f0 = n_fe;
    do_start(4);
    do_bit(1'b1, 2, 2, 4);
    do_bit(1'b0, 2, 2, 4);
    do_bit(1'b1, 2, 2, 4);
    wait_n(TO + S + 2);
    chk("timeout_fe_count", 32'(n_fe - f0), 32'd1);
    chk("timeout_busy", 32'(bus.busy), 32'd0);
    bus.sda = 1'b1;
    wait_n(4);
    frame(4'b0110, 2, 2, 4);
    wait_n(4);
    chk("timeout_next_data", 32'(bus.data), 32'h6);
    chk("timeout_fe_once", 32'(n_fe - f0), 32'd1);

    f0 = n_fe;
    do_start(4);
    do_bit(1'b0, 2, 2, 4);
    do_bit(1'b1, 2, 2, 4);
    rst = 1'b1;
    #1;
    chk("rst_async_data", 32'(bus.data), 32'd0);
    chk("rst_async_outhigh", 32'(bus.outhigh), 32'd0);
    chk("rst_async_busy", 32'(bus.busy), 32'd0);
    bus.scl = 1'b1;
    bus.sda = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(3);
    frame(4'b0101, 2, 2, 4);
    wait_n(4);
    chk("after_rst_data", 32'(bus.data), 32'h5);
    chk("after_rst_outhigh", 32'(bus.outhigh), 32'h0020);
    chk("after_rst_no_fe", 32'(n_fe - f0), 32'd0);

    d0 = n_dv;
    f0 = n_fe;
    do_start(4);
    v = 4'b0011;
    for (int i = NB - 1; i >= 0; i--) do_bit(v[i], 2, 2, 4);
    do_bit(1'b1, 2, 2, 4);
    do_start(4);
    wait_n(2);
    chk("rstart_busy", 32'(bus.busy), 32'd1);
    chk("rstart_fe_count", 32'(n_fe - f0), 32'd1);
    v = 4'b1001;
    for (int i = NB - 1; i >= 0; i--) do_bit(v[i], 2, 2, 4);
    do_bit(1'b0, 2, 2, 4);
    do_stop(4);
    wait_n(4);
    chk("rstart_data", 32'(bus.data), 32'h9);
    chk("rstart_dv_count", 32'(n_dv - d0), 32'd1);
    chk("rstart_fe_once", 32'(n_fe - f0), 32'd1);

    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      lo1 = $urandom_range(1, 3);
      lo2 = $urandom_range(1, 3);
      hi = $urandom_range(1, 4);
      n = $urandom_range(0, 3);
      v = 4'($urandom);
      if (kind == 6) begin
        do_start(hi);
        for (int i = 0; i < n; i++) do_bit((i == n - 1) ? 1'b0 : 1'($urandom), lo1, lo2, hi);
        do_stop(hi);
      end else if (kind == 7) begin
        do_start(hi);
        for (int i = 0; i < n + 2; i++) do_bit(1'($urandom), lo1, lo2, hi);
        do_bit(1'b1, lo1, lo2, hi);
        do_start(hi);
        for (int i = NB - 1; i >= 0; i--) do_bit(v[i], lo1, lo2, hi);
        do_bit(1'b0, lo1, lo2, hi);
        do_stop(hi);
      end else if (kind == 8) begin
        do_start(hi);
        for (int i = 0; i < n; i++) do_bit(1'($urandom), lo1, lo2, hi);
        wait_n(TO + 8);
        bus.sda = 1'b1;
        wait_n(2);
      end else if (kind == 9) begin
        do_start(hi);
        for (int i = 0; i < n; i++) do_bit(1'($urandom), lo1, lo2, hi);
        rst = 1'b1;
        wait_n(2);
        bus.scl = 1'b1;
        bus.sda = 1'b1;
        wait_n(2);
        rst = 1'b0;
        wait_n(2);
      end else frame(v, lo1, lo2, hi);
      wait_n($urandom_range(1, 6));
    end
    wait_n(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sda_rx.md
# sda_rx

Serial receiver that sits directly downstream of the parallel-to-serial `scl`/`sda` transmitter. It monitors the two-wire bus and recognises the start and stop conditions. It captures the NBITS data bits (MSB first), checks framing, and presents each received nibble as a parallel word, a one-cycle valid strobe and a registered one-hot decode (`outhigh`) for the display/decoder logic that follows.

## Interface
- NBITS, 4, data bits per frame
- SYNC_STAGES, 2, flip-flop synchroniser depth on `scl` and `sda` (≥2)
- TIMEOUT, 64, `sclk` cycles with no `scl` edge before an open frame is aborted
- sclk  input  1  receiver system clock; must run ≥4× the `scl` bit clock
- rst  input  1  asynchronous, active-high reset
- scl  input  1  serial bus clock from the transmitter
- sda  input  1  serial bus data (the receiver never drives it)
- data  output  NBITS  last correctly framed word
- data_valid  output  1  one-cycle pulse; `data` and `outhigh` updated this cycle
- frame_err  output  1  one-cycle pulse on an aborted or malformed frame
- busy  output  1  high from start detection until frame end or abort
- outhigh  output  2**NBITS  one-hot of `data` (bit `data` set), held between frames

## Operation
- Synchronised samples `scl_s` and `sda_s` are compared against their previous values `scl_p` and `sda_p`.
  - start = `scl_s & scl_p & sda_p & !sda_s`
  - stop = `scl_s & scl_p & !sda_p & sda_s`
  - bit strobe = `scl_s & !scl_p`
- Data changes while `scl` is high are start/stop conditions only.
- If `scl` and `sda` change in the same sample, there is no start/stop. Only the bit strobe applies, and it uses the new `sda_s`.
- FSM states are IDLE, BITS, STOP_WAIT.
  - IDLE → BITS on start: clear the bit counter and shift register, assert `busy`. Stop and bit strobes are ignored in IDLE.
  - BITS: on each bit strobe, shift `sda_s` into the LSB and increment the counter. After the NBITS-th strobe → STOP_WAIT.
  - STOP_WAIT: bit strobes are ignored; this covers the transmitter's trailing low bit.
- Frame completion: stop in STOP_WAIT →
  - `data` ← shift register
  - `outhigh` ← one-hot of the shift register
  - `data_valid` pulse
  - → IDLE, `busy` low
- Error cases:
  - Stop in BITS → `frame_err`, → IDLE.
  - Start in BITS or STOP_WAIT (repeated start) → `frame_err`, → BITS with a cleared counter and shift register; `busy` stays high.
- Timeout:
  - The idle counter resets on every `scl_s` edge and in IDLE.
  - When it reaches TIMEOUT in BITS/STOP_WAIT → `frame_err`, → IDLE.
- `data` and `outhigh` change only on `data_valid`; errors never corrupt them.

## Timing
- Reset values: `data`=0, `data_valid`=0, `frame_err`=0, `busy`=0, `outhigh`=0, state IDLE, synchronisers = 1 (bus idle high).
- Reset is asynchronous at any point. A frame interrupted by reset is discarded with no `frame_err`. The receiver resumes on the next start after release.
- Latency from a raw `sda` edge to its detection: SYNC_STAGES cycles.
  - `data_valid`, `frame_err` and `busy` are registered and assert on the following `sclk` edge, i.e. SYNC_STAGES+1 cycles after the raw edge.
- `data_valid` and `frame_err` never assert in the same cycle. Each pulse is exactly one `sclk` cycle.
- Back-to-back frames need no gap beyond the bus stop-to-start spacing. A start one cycle after `data_valid` is accepted.
- Bit counter width is clog2(NBITS+1); it never wraps within a frame. The timeout counter saturates at TIMEOUT.

## Structure
- Shared package `sda_pkg`:
  - state enum (IDLE, BITS, STOP_WAIT)
  - default NBITS / TIMEOUT constants
  - one-hot decode function, shared with future decoder blocks
- Sub-module `sync_edge`: SYNC_STAGES-deep synchroniser plus previous-sample register, with reset value 1. It outputs the synced level and previous level and is instantiated once for `scl` and once for `sda`.
- The top level holds the FSM, shift register, bit and timeout counters, and output registers.

## Test plan
- Frame 1011 with scl at 1/8 `sclk` → `data`=4'hB, `outhigh`=16'h0800, one `data_valid` pulse at SYNC_STAGES+1 cycles after the stop edge; `busy` low afterwards.
- Back-to-back frames 0000 then 1111 → two `data_valid` pulses; `data` 0 then F; `outhigh` 16'h0001 then 16'h8000.
- Start, 2 bits, stop → single `frame_err` pulse, no `data_valid`; `data`/`outhigh` keep the prior value 4'hB.
- Start, 3 bits, `scl` held for TIMEOUT+SYNC_STAGES+2 cycles → `frame_err` once; `busy` falls; a following frame 0110 gives `data`=4'h6.
- Assert `rst` after bit 2 of a frame → all outputs 0 immediately, no `frame_err`; after release, frame 0101 gives `data`=4'h5, `outhigh`=16'h0020.
- Repeated start during STOP_WAIT, then frame 1001 → one `frame_err`, `busy` stays high, then `data`=4'h9, `data_valid` once.
